pcie_bas_wr_arbiter: RTL and testbench

// - Shares the single PCIe BAS write port between NUM_REQ Avalon-MM burst-write masters.

---
 rtl/pcie_bas_wr_arbiter_pkg.sv | 23 ++
 rtl/pcie_bas_wr_arbiter_rr_pick.sv | 29 ++
 rtl/pcie_bas_wr_arbiter.sv | 149 ++++++++++++++
 tb/tb_pcie_bas_wr_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pcie_bas_wr_arbiter_pkg.sv
// Shared types and constants for the PCIe BAS write-port arbiter.
package pcie_bas_wr_arbiter_pkg;

  localparam int BAS_MAX_BURST = 8;

  typedef struct packed {
    logic [63:0]  address;
    logic [63:0]  byteenable;
    logic [511:0] writedata;
    logic [3:0]   burstcount;
  } bas_wr_t;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } arb_state_t;

  // Burst lengths the BAS cannot take are demoted to a single beat.
  function automatic logic burst_is_bad(input logic [3:0] n);
    return (n == 4'd0) || (n > 4'(BAS_MAX_BURST));
  endfunction

endpackage

// File: rtl/pcie_bas_wr_arbiter_rr_pick.sv
// Cyclic priority encoder: first set, non-excluded request at or after start.
module pcie_bas_wr_arbiter_rr_pick #(
  parameter int NUM_REQ = 2,
  localparam int IDX_W  = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  input  logic [NUM_REQ-1:0] excl,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  int p;

  // Scan from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    p     = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      p = (int'(start) + k) % NUM_REQ;
      if (req[p] && !excl[p]) begin
        valid = 1'b1;
        idx   = IDX_W'(p);
      end
    end
  end

endmodule

// File: rtl/pcie_bas_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing the PCIe BAS write port between masters.
module pcie_bas_wr_arbiter
  import pcie_bas_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int CNT_WIDTH = 32,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ*64-1:0]  req_address,
  input  logic [NUM_REQ*64-1:0]  req_byteenable,
  input  logic [NUM_REQ-1:0]     req_write,
  input  logic [NUM_REQ*512-1:0] req_writedata,
  input  logic [NUM_REQ*4-1:0]   req_burstcount,
  output logic [NUM_REQ-1:0]     req_waitrequest,
  input  logic                   pcie_bas_waitrequest,
  output logic [63:0]            pcie_bas_address,
  output logic [63:0]            pcie_bas_byteenable,
  output logic                   pcie_bas_write,
  output logic [511:0]           pcie_bas_writedata,
  output logic [3:0]             pcie_bas_burstcount,
  output logic                   pcie_bas_read,
  input  logic                   sw_reset,
  output logic [CNT_WIDTH-1:0]   arb_wait_cnt,
  output logic [CNT_WIDTH-1:0]   bad_burst_cnt
);

  arb_state_t         state;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   rr_ptr;
  logic [3:0]         beats_left;
  logic               first_beat;
  bas_wr_t            sel;
  bas_wr_t            hold;

  logic               active;
  logic               acc;
  logic               bad;
  logic [3:0]         n_eff;
  logic               last;
  logic               wait_any;
  logic [IDX_W-1:0]   grant_inc;
  logic [NUM_REQ-1:0] gnt_mask;
  logic [IDX_W-1:0]   pick_start;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  assign active    = (state == ST_ACTIVE);
  assign grant_inc = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

  always_comb begin
    sel.address    = req_address[grant_idx*64 +: 64];
    sel.byteenable = req_byteenable[grant_idx*64 +: 64];
    sel.writedata  = req_writedata[grant_idx*512 +: 512];
    sel.burstcount = req_burstcount[grant_idx*4 +: 4];
  end

  always_comb begin
    gnt_mask = '0;
    if (active) gnt_mask[grant_idx] = 1'b1;
  end

  always_comb begin
    req_waitrequest = '1;
    if (active) req_waitrequest[grant_idx] = pcie_bas_waitrequest;
  end

  assign acc      = active && req_write[grant_idx] && !pcie_bas_waitrequest;
  assign bad      = burst_is_bad(sel.burstcount);
  assign n_eff    = bad ? 4'd1 : sel.burstcount;
  assign last     = acc && (first_beat ? (n_eff == 4'd1) : (beats_left == 4'd1));
  assign wait_any = |(req_write & ~gnt_mask);

  // Idle arbitration starts at rr_ptr; last-beat arbitration skips the current owner.
  assign pick_start = active ? grant_inc : rr_ptr;

  pcie_bas_wr_arbiter_rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .req   (req_write),
    .start (pick_start),
    .excl  (gnt_mask),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign pcie_bas_write      = active && req_write[grant_idx];
  assign pcie_bas_address    = active ? sel.address    : hold.address;
  assign pcie_bas_byteenable = active ? sel.byteenable : hold.byteenable;
  assign pcie_bas_writedata  = active ? sel.writedata  : hold.writedata;
  assign pcie_bas_burstcount = active ? sel.burstcount : hold.burstcount;
  assign pcie_bas_read       = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      grant_idx     <= '0;
      rr_ptr        <= '0;
      beats_left    <= '0;
      first_beat    <= 1'b0;
      hold          <= '0;
      arb_wait_cnt  <= '0;
      bad_burst_cnt <= '0;
    end else begin
      if (active) hold <= sel;

      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            grant_idx  <= pick_idx;
            first_beat <= 1'b1;
            state      <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (acc) begin
            if (first_beat) begin
              beats_left <= n_eff - 4'd1;
              first_beat <= 1'b0;
            end else begin
              beats_left <= beats_left - 4'd1;
            end
            if (last) begin
              rr_ptr <= grant_inc;
              if (pick_valid) begin
                grant_idx  <= pick_idx;
                first_beat <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
        end
        default: state <= ST_IDLE;
      endcase

      // Counters are statistics only; clearing them never disturbs a burst.
      if (sw_reset) begin
        arb_wait_cnt  <= '0;
        bad_burst_cnt <= '0;
      end else begin
        if (wait_any && (arb_wait_cnt != '1))
          arb_wait_cnt <= arb_wait_cnt + CNT_WIDTH'(1);
        if (acc && first_beat && bad && (bad_burst_cnt != '1))
          bad_burst_cnt <= bad_burst_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_pcie_bas_wr_arbiter.sv
// Bench for pcie_bas_wr_arbiter: directed scenarios plus random traffic against a burst-level model.
module tb_pcie_bas_wr_arbiter;

  localparam int N  = 3;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, sw_reset, pcie_bas_waitrequest;
  logic [N*64-1:0]  req_address, req_byteenable;
  logic [N-1:0]     req_write, req_waitrequest;
  logic [N*512-1:0] req_writedata;
  logic [N*4-1:0]   req_burstcount;
  logic [63:0]      pcie_bas_address, pcie_bas_byteenable;
  logic             pcie_bas_write, pcie_bas_read;
  logic [511:0]     pcie_bas_writedata;
  logic [3:0]       pcie_bas_burstcount;
  logic [CW-1:0]    arb_wait_cnt, bad_burst_cnt;

  pcie_bas_wr_arbiter #(.NUM_REQ(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_address(req_address), .req_byteenable(req_byteenable),
    .req_write(req_write), .req_writedata(req_writedata),
    .req_burstcount(req_burstcount), .req_waitrequest(req_waitrequest),
    .pcie_bas_waitrequest(pcie_bas_waitrequest),
    .pcie_bas_address(pcie_bas_address), .pcie_bas_byteenable(pcie_bas_byteenable),
    .pcie_bas_write(pcie_bas_write), .pcie_bas_writedata(pcie_bas_writedata),
    .pcie_bas_burstcount(pcie_bas_burstcount), .pcie_bas_read(pcie_bas_read),
    .sw_reset(sw_reset), .arb_wait_cnt(arb_wait_cnt), .bad_burst_cnt(bad_burst_cnt)
  );

  // Master-side drive state
  logic [63:0]  m_addr [N];
  logic [63:0]  m_be   [N];
  logic [511:0] m_data [N];
  logic [3:0]   m_bc   [N];
  logic         m_wr   [N];
  int           rem    [N];

  always_comb begin
    req_address = '0; req_byteenable = '0; req_writedata = '0;
    req_burstcount = '0; req_write = '0;
    for (int i = 0; i < N; i++) begin
      req_address[i*64 +: 64]    = m_addr[i];
      req_byteenable[i*64 +: 64] = m_be[i];
      req_writedata[i*512 +: 512] = m_data[i];
      req_burstcount[i*4 +: 4]   = m_bc[i];
      req_write[i]               = m_wr[i];
    end
  end

  // Reference model: who owns the port and how many beats of its burst remain.
  bit            busy;
  int            g, ptr, left;
  logic [CW-1:0] wait_cnt, bad_cnt;

  int vectors, miscompares, seen0;

  function automatic int eff(input logic [3:0] bc);
    return (bc == 0 || bc > 8) ? 1 : int'(bc);
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_beat(input int i);
    m_addr[i] = {$urandom, $urandom};
    m_be[i]   = {$urandom, $urandom};
    for (int k = 0; k < 16; k++) m_data[i][k*32 +: 32] = $urandom;
  endtask

  task automatic launch(input int i, input logic [3:0] bc);
    new_beat(i);
    m_bc[i] = bc;
    rem[i]  = eff(bc);
    m_wr[i] = 1'b1;
  endtask

  task automatic clear_masters();
    for (int i = 0; i < N; i++) begin
      m_wr[i] = 1'b0; rem[i] = 0; m_bc[i] = '0;
      m_addr[i] = '0; m_be[i] = '0; m_data[i] = '0;
    end
  endtask

  task automatic cycle();
    logic [N-1:0] exp_wr;
    logic         exp_write;
    bit           acc, waitany, found;
    int           ag, nxt, j;
    #2;
    exp_wr = '1; exp_write = 1'b0;
    if (busy) begin
      exp_wr[g] = pcie_bas_waitrequest;
      exp_write = m_wr[g];
    end
    chk("req_waitrequest", req_waitrequest, exp_wr);
    chk("bas_write", pcie_bas_write, exp_write);
    chk("bas_read", pcie_bas_read, 0);
    if (busy) begin
      chk("bas_address", pcie_bas_address, m_addr[g]);
      chk("bas_byteenable", pcie_bas_byteenable, m_be[g]);
      chk("bas_writedata", pcie_bas_writedata, m_data[g]);
      chk("bas_burstcount", pcie_bas_burstcount, m_bc[g]);
    end
    chk("arb_wait_cnt", arb_wait_cnt, wait_cnt);
    chk("bad_burst_cnt", bad_burst_cnt, bad_cnt);
    if (req_write[0] && !req_waitrequest[0]) seen0++;
    acc = busy && m_wr[g] && !pcie_bas_waitrequest;
    ag  = g;
    @(posedge clk);
    if (rst) begin
      busy = 0; g = 0; ptr = 0; left = 0; wait_cnt = '0; bad_cnt = '0;
    end else begin
      waitany = 0;
      for (int i = 0; i < N; i++) if (m_wr[i] && !(busy && i == g)) waitany = 1;
      if (sw_reset) wait_cnt = '0;
      else if (waitany && wait_cnt != '1) wait_cnt++;
      if (sw_reset) bad_cnt = '0;
      if (!busy) begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          j = (ptr + k) % N;
          if (!found && m_wr[j]) begin found = 1; g = j; end
        end
        if (found) begin busy = 1; left = -1; end
      end else if (acc) begin
        if (left < 0) begin
          if (m_bc[g] == 0 || m_bc[g] > 8) begin
            if (!sw_reset && bad_cnt != '1) bad_cnt++;
            left = 0;
          end else left = int'(m_bc[g]) - 1;
        end else left--;
        if (left == 0) begin
          ptr = (g + 1) % N;
          found = 0; nxt = 0;
          for (int k = 1; k < N; k++) begin
            j = (g + k) % N;
            if (!found && m_wr[j]) begin found = 1; nxt = j; end
          end
          if (found) begin g = nxt; left = -1; end
          else busy = 0;
        end
      end
    end
    #1;
    if (acc && !rst) begin
      rem[ag]--;
      if (rem[ag] == 0) m_wr[ag] = 1'b0;
      else begin new_beat(ag); m_bc[ag] = 4'($urandom); end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  initial begin
    vectors = 0; miscompares = 0; seen0 = 0;
    rst = 1'b1; sw_reset = 1'b0; pcie_bas_waitrequest = 1'b0;
    clear_masters();
    busy = 0; g = 0; ptr = 0; left = 0; wait_cnt = '0; bad_cnt = '0;
    @(posedge clk); #1;
    run(2);
    rst = 1'b0;
    run(2);

    // single beat from master 0
    launch(0, 4'd1);
    run(5);

    // two full-length bursts requested together
    launch(0, 4'd8); launch(1, 4'd8);
    run(20);

    // back-pressure on beat 2 while master 1 waits
    seen0 = 0;
    launch(0, 4'd4); launch(1, 4'd1);
    cycle(); cycle();
    pcie_bas_waitrequest = 1'b1;
    run(3);
    pcie_bas_waitrequest = 1'b0;
    run(8);
    chk("m0_accepted_beats", 32'(seen0), 4);

    // illegal first-beat burst lengths
    rst = 1'b1; cycle(); rst = 1'b0;
    launch(0, 4'd0); run(4);
    launch(0, 4'd9); run(4);
    chk("bad_burst_total", bad_burst_cnt, 2);

    // counter clear mid-burst
    launch(0, 4'd8); launch(2, 4'd2);
    run(3);
    sw_reset = 1'b1; cycle(); sw_reset = 1'b0;
    chk("sw_reset_wait_clear", arb_wait_cnt, 0);
    chk("sw_reset_bad_clear", bad_burst_cnt, 0);
    run(20);

    // reset on beat 3 of 8
    launch(0, 4'd8);
    run(3);
    rst = 1'b1; clear_masters();
    cycle();
    rst = 1'b0;
    #1;
    chk("rst_bas_write", pcie_bas_write, 0);
    chk("rst_waitrequest", req_waitrequest, {N{1'b1}});
    run(2);

    // random traffic
    for (int c = 0; c < 800; c++) begin
      pcie_bas_waitrequest = ($urandom_range(0, 3) == 0);
      sw_reset = ($urandom_range(0, 59) == 0);
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          if ($urandom_range(0, 3) == 0) launch(i, 4'($urandom_range(0, 15)));
        end else begin
          m_wr[i] = ($urandom_range(0, 9) != 0);
        end
      end
      cycle();
    end
    sw_reset = 1'b0; pcie_bas_waitrequest = 1'b0;
    for (int i = 0; i < N; i++) if (rem[i] > 0) m_wr[i] = 1'b1;
    run(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
